// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Latency: done is high in the cycle after edge k+WIDTH+1 when start is accepted at edge k.
// Backpressure: none; start is ignored while busy, so results repeat at best every WIDTH+2 cycles.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset; aborts any conversion
//   start  - conversion request, accepted only in IDLE
//   bin    - unsigned binary input, sampled on the accepting edge
//   busy   - high while converting (SHIFT and LOAD)
//   done   - one-cycle pulse when a new result appears on bcd/ovf/blank
//   bcd    - six BCD digits, [3:0] units ... [23:20] hundred-thousands
//   ovf    - last accepted input exceeded 999999 (result saturated)
//   blank  - per-digit leading-zero mask
//
// Build option: define BIN2BCD_LZ_BLANK_EN to generate the leading-zero mask;
// otherwise blank is tied to zero.
module bin2bcd_seq #(
   parameter int WIDTH = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [23:0]      bcd,
   output logic             ovf,
   output logic [5:0]       blank
);

   // Counter only has to reach WIDTH-1; it may wrap on the final
   // increment, which is harmless because LOAD ignores it.
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CW-1:0]       r_cnt;
   logic [WIDTH-1:0]    r_op;
   logic [23:0]         r_scratch;
   logic                r_ovf_pend;
   logic                r_done;
   logic [23:0]         r_bcd;
   logic                r_ovf;

   logic                w_accept;
   logic                w_last;
   logic                w_clamp;
   logic [WIDTH-1:0]    w_bin_lat;
   logic [23:0]         w_adj;
   logic [23+WIDTH:0]   w_shifted;

   // Six digits only hold 999999; narrower inputs can never reach it,
   // so the comparison folds away for WIDTH < 20.
   assign w_clamp   = (32'(bin) > 32'd999999);
   assign w_bin_lat = w_clamp ? WIDTH'(32'd999999) : bin;
   assign w_last    = (r_cnt == CW'(WIDTH-1));

   // Add-3 correction applied before the shift so that no digit
   // exceeds 9 after doubling.
   always_comb begin
      w_adj = r_scratch;
      for (int i = 0; i < 6; i++) begin
         if (r_scratch[i*4 +: 4] >= 4'd5)
            w_adj[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
      end
   end

   assign w_shifted = {w_adj, r_op} << 1;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      busy     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = SHIFT;
            end
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last)
               w_next = LOAD;
         end
         LOAD: begin
            busy   = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= '0;
         r_op       <= '0;
         r_scratch  <= '0;
         r_ovf_pend <= 1'b0;
         r_done     <= 1'b0;
         r_bcd      <= '0;
         r_ovf      <= 1'b0;
      end else begin
         // Registered so the pulse lines up with the registered result.
         r_done <= (r_state == LOAD);
         if (w_accept) begin
            r_op       <= w_bin_lat;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_clamp;
         end else if (r_state == SHIFT) begin
            r_scratch <= w_shifted[23+WIDTH:WIDTH];
            r_op      <= w_shifted[WIDTH-1:0];
            r_cnt     <= r_cnt + 1'b1;
         end else if (r_state == LOAD) begin
            r_bcd <= r_scratch;
            r_ovf <= r_ovf_pend;
         end
      end
   end

   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;

`ifdef BIN2BCD_LZ_BLANK_EN
   logic [5:0] r_blank;
   logic [5:0] w_blank;

   // Walk from the top digit down; a digit is blanked while every digit
   // above it (and itself) is zero. Units digit is never blanked.
   always_comb begin
      logic v_lead;
      v_lead  = 1'b1;
      w_blank = '0;
      for (int i = 5; i >= 1; i--) begin
         v_lead     = v_lead & (r_scratch[i*4 +: 4] == 4'd0);
         w_blank[i] = v_lead;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_blank <= 6'b111110;
      else if (r_state == LOAD)
         r_blank <= w_blank;
   end

   assign blank = r_blank;
`else
   assign blank = 6'b000000;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [19:0] bin = '0;
   logic        busy;
   logic        done;
   logic [23:0] bcd;
   logic        ovf;
   logic [5:0]  blank;

   int checks = 0;
   int failures = 0;

`ifdef BIN2BCD_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   always #5 clk = ~clk;

   bin2bcd_seq #(.WIDTH(20)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf),
      .blank (blank)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] ref_bcd(input int unsigned v);
      int unsigned x;
      logic [23:0] r;
      x = (v > 999999) ? 999999 : v;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [5:0] ref_blank(input logic [23:0] d);
      logic [5:0] r;
      logic lead;
      r = '0;
      lead = 1'b1;
      if (LZ) begin
         for (int i = 5; i >= 1; i--) begin
            lead = lead & (d[i*4 +: 4] == 4'd0);
            r[i] = lead;
         end
      end
      return r;
   endfunction

   // Called at a falling edge; leaves the bench at the falling edge on
   // which done is first seen, so the next call starts back-to-back.
   task automatic convert(input string tag, input logic [19:0] b, input logic [23:0] e_bcd,
                          input logic e_ovf, input logic [5:0] e_blank);
      int n;
      logic nib_ok;
      start = 1'b1;
      bin   = b;
      @(negedge clk);
      start = 1'b0;
      bin   = ~b;   // input must not matter after the accepting edge
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, 21);
      check({tag, "_bcd"}, bcd, e_bcd);
      check({tag, "_ovf"}, ovf, e_ovf);
      check({tag, "_blank"}, blank, e_blank);
      check({tag, "_busy"}, busy, 1'b0);
      nib_ok = 1'b1;
      for (int i = 0; i < 6; i++)
         if (bcd[i*4 +: 4] > 4'd9) nib_ok = 1'b0;
      check({tag, "_nibbles"}, nib_ok, 1'b1);
   endtask

   initial begin
      int nb;
      int nd;
      logic [19:0] v;

      // Reset, with start held high to show reset wins.
      rst   = 1'b1;
      start = 1'b1;
      bin   = 20'd123;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bcd", bcd, 24'h000000);
      check("rst_ovf", ovf, 1'b0);
      check("rst_blank", blank, LZ ? 6'b111110 : 6'b000000);
      start = 1'b0;

      // First edge with rst low accepts.
      rst = 1'b0;
      convert("zero", 20'd0, 24'h000000, 1'b0, LZ ? 6'b111110 : 6'b000000);
      @(negedge clk);
      check("done_pulse_width", done, 1'b0);

      convert("v123456", 20'd123456, 24'h123456, 1'b0, 6'b000000);
      convert("v42", 20'd42, 24'h000042, 1'b0, LZ ? 6'b111100 : 6'b000000);
      convert("v999999", 20'd999999, 24'h999999, 1'b0, 6'b000000);
      convert("vFFFFF", 20'hFFFFF, 24'h999999, 1'b1, 6'b000000);

      // Outputs hold while idle.
      repeat (5) @(negedge clk);
      check("hold_bcd", bcd, 24'h999999);
      check("hold_ovf", ovf, 1'b1);
      check("hold_done", done, 1'b0);

      convert("v1000000", 20'd1000000, 24'h999999, 1'b1, 6'b000000);
      convert("v500000", 20'd500000, 24'h500000, 1'b0, 6'b000000);

      // Starts during SHIFT and during LOAD are ignored.
      @(negedge clk);
      start = 1'b1;
      bin   = 20'd500;
      @(negedge clk);
      start = 1'b0;
      nb = 0;
      nd = 0;
      for (int m = 0; m <= 30; m++) begin
         if (busy === 1'b1) nb++;
         if (done === 1'b1) nd++;
         start = (m == 5 || m == 20);
         bin   = 20'd777;
         @(negedge clk);
      end
      start = 1'b0;
      check("ign_done_count", nd, 1);
      check("ign_busy_cycles", nb, 21);
      check("ign_bcd", bcd, 24'h000500);
      check("ign_ovf", ovf, 1'b0);
      check("ign_blank", blank, LZ ? 6'b111000 : 6'b000000);

      // Reset aborts a conversion at iteration 10.
      start = 1'b1;
      bin   = 20'd654321;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_bcd", bcd, 24'h000000);
      check("abort_done", done, 1'b0);
      check("abort_blank", blank, LZ ? 6'b111110 : 6'b000000);
      nd = 0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) nd++;
      end
      check("abort_no_done", nd, 0);
      check("abort_idle_busy", busy, 1'b0);
      convert("after_abort", 20'd7, 24'h000007, 1'b0, LZ ? 6'b111110 : 6'b000000);

      // Random back-to-back conversions, one every 22 cycles.
      for (int r = 0; r < 12; r++) begin
         v = 20'($urandom_range(0, 1048575));
         convert("rand", v, ref_bcd(32'(v)), (v > 20'd999999),
                 ref_blank(ref_bcd(32'(v))));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 20, meaning binary input width, legal range 4..20.
REQ-002 The block SHALL have port clk  input  1  the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 The block SHALL have port bin  input  WIDTH  unsigned binary value, sampled on the edge that accepts start.
REQ-006 The block SHALL have port busy  output  1  conversion in progress.
REQ-007 The block SHALL have port done  output  1  one-cycle pulse marking that a new result is present on bcd.
REQ-008 The block SHALL have port bcd  output  24  six BCD digits: [3:0] is units, [23:20] is hundred-thousands; each nibble feeds one 7-segment decoder.
REQ-009 The block SHALL have port ovf  output  1  set when the last accepted bin exceeded 999999.
REQ-010 The block SHALL have port blank  output  6  leading-zero mask, one bit per digit (see Configuration).

Function
REQ-011 The block SHALL be an FSM with exactly three states: IDLE, SHIFT and LOAD.
REQ-012 In IDLE with start=1, the block SHALL latch bin, clear the scratch BCD register, clear the iteration counter and go to SHIFT.
REQ-013 In IDLE with start=0, the block SHALL hold all outputs.
REQ-014 For WIDTH=20 and bin>999999, the latched value SHALL be 999999 and the ovf result SHALL be 1; otherwise the ovf result SHALL be 0.
REQ-015 Each SHIFT cycle SHALL perform one double-dabble iteration: add 3 to every scratch BCD nibble >=5, then shift {scratch, operand} left by one bit.
REQ-016 SHIFT SHALL last exactly WIDTH cycles, counted by the iteration counter, and then go to LOAD.
REQ-017 In LOAD, the block SHALL copy scratch to bcd, update ovf and blank, drive done=1 for exactly that one cycle, and return to IDLE.
REQ-018 The latency SHALL be: if start is accepted at edge k, done is high in the cycle following edge k+WIDTH+1, and bcd/ovf/blank are valid in that same cycle.
REQ-019 busy SHALL be 1 in SHIFT and LOAD and 0 in IDLE.
REQ-020 start SHALL be ignored while busy=1, and the in-flight conversion SHALL be unaffected.
REQ-021 A start that is high in the LOAD cycle SHALL be ignored; a new conversion SHALL be accepted at the earliest on the next edge in IDLE, giving a back-to-back period of WIDTH+2 cycles.
REQ-022 bcd, ovf and blank SHALL change only in LOAD and SHALL hold their values between results.
REQ-023 Every bcd nibble SHALL always be in the range 0..9.
REQ-024 Changes on bin outside the accepting edge SHALL have no effect.

Reset
REQ-025 When rst=1 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, bcd=24'h000000, ovf=0, blank=6'b111110, counter=0 and scratch=0.
REQ-026 Reset SHALL take priority over start and SHALL abort a conversion in progress; no done SHALL be produced for an aborted conversion.
REQ-027 The first start SHALL be accepted on the first edge with rst=0.

Configuration
REQ-028 The feature SHALL be controlled by the macro BIN2BCD_LZ_BLANK_EN.
REQ-029 With BIN2BCD_LZ_BLANK_EN defined, in LOAD the block SHALL set blank[i]=1 for every digit i>0 that is zero and more significant than the highest nonzero digit.
REQ-030 With BIN2BCD_LZ_BLANK_EN defined, blank[0] SHALL always be 0, so value 0 shows a single "0".
REQ-031 Without BIN2BCD_LZ_BLANK_EN, blank SHALL be constant 6'b000000, including during reset, and no blanking logic SHALL be synthesized.

Verification
REQ-032 Reset, then start with bin=0 (WIDTH=20) -> done exactly 21 cycles after the accepting edge; bcd=24'h000000; ovf=0; blank=6'b111110 with the macro, 6'b000000 without.
REQ-033 bin=123456 -> bcd=24'h123456, ovf=0, blank=6'b000000; bin=42 -> bcd=24'h000042, blank=6'b111100 with the macro.
REQ-034 bin=999999 -> bcd=24'h999999, ovf=0; bin=20'hFFFFF (1048575) -> bcd=24'h999999, ovf=1.
REQ-035 Start bin=500, then pulse start with bin=777 during SHIFT and in the LOAD cycle -> exactly one done; bcd=24'h000500; busy high for exactly 21 cycles.
REQ-036 Start bin=654321, assert rst at iteration 10 -> busy=0, bcd=24'h000000, no done; then start bin=7 -> bcd=24'h000007 after 21 cycles.
REQ-037 Random bin values 0..1048575 with back-to-back starts every 22 cycles -> every bcd matches a reference model of min(bin,999999) and every nibble is <=9.
